// File: rtl/spi_txn_ctrl_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RUN,
      HOLD,
      RSP
   } spi_state_e;

   localparam int SPI_MAXLEN_DEF = 16;
   localparam int SPI_MIN_DIVIDE = 2;

   // Width of a bit-count field able to hold 0..maxlen.
   function automatic int spi_len_w(input int maxlen);
      return $clog2(maxlen) + 1;
   endfunction

   localparam int SPI_LEN_W = spi_len_w(SPI_MAXLEN_DEF);

endpackage

// File: rtl/spi_txn_ctrl_if.sv
// Host-side request/response channels of the SPI transaction sequencer.
interface spi_txn_ctrl_if
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN = 16,
   parameter int DIV_W      = 16
);
   localparam int LEN_W = spi_len_w(SPI_MAXLEN);

   logic                  req_valid;
   logic                  req_ready;
   logic [LEN_W-1:0]      req_len;
   logic [SPI_MAXLEN-1:0] req_tx_data;
   logic [DIV_W-1:0]      req_divide;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [SPI_MAXLEN-1:0] rsp_rx_data;
   logic                  rsp_err;

   // Host side: issues requests, consumes responses.
   modport master (
      output req_valid, req_len, req_tx_data, req_divide, rsp_ready,
      input  req_ready, rsp_valid, rsp_rx_data, rsp_err
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_len, req_tx_data, req_divide, rsp_ready,
      output req_ready, rsp_valid, rsp_rx_data, rsp_err
   );
endinterface

// File: rtl/spi_txn_ctrl_shift_reg.sv
// spi_clk edge detector plus MOSI/MISO shift registers for mode 0.
module spi_shift_reg
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN = 16,
   localparam int LEN_W     = spi_len_w(SPI_MAXLEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  run_i,
   input  logic [LEN_W-1:0]      len_i,
   input  logic [SPI_MAXLEN-1:0] tx_i,
   input  logic                  spi_clk_i,
   input  logic                  miso_i,
   output logic                  mosi_o,
   output logic [SPI_MAXLEN-1:0] rx_o
);
   localparam int IDX_W = $clog2(SPI_MAXLEN);
   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   logic                  spi_clk_q;
   logic                  mosi_q;
   logic [SPI_MAXLEN-1:0] tx_q;
   logic [SPI_MAXLEN-1:0] rx_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      bit_cnt_q;
   logic                  rise;
   logic                  fall;
   logic                  more_bits;
   logic [IDX_W-1:0]      load_idx;
   logic [IDX_W-1:0]      next_idx;

   assign rise      = !spi_clk_q && spi_clk_i;
   assign fall      = spi_clk_q && !spi_clk_i;
   assign more_bits = bit_cnt_q < len_q;
   // MSB of the word is bit len-1; after k sampled bits the next one is len-1-k.
   assign load_idx  = IDX_W'(len_i - ONE);
   assign next_idx  = IDX_W'(len_q - bit_cnt_q - ONE);

   // Sample on rising edges, present next MOSI bit on falling edges; extra edges are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_clk_q <= 1'b0;
         mosi_q    <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         len_q     <= '0;
         bit_cnt_q <= '0;
      end else begin
         spi_clk_q <= spi_clk_i;
         if (load_i) begin
            tx_q      <= tx_i;
            len_q     <= len_i;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= tx_i[load_idx];
         end else if (run_i) begin
            if (rise && more_bits) begin
               rx_q      <= {rx_q[SPI_MAXLEN-2:0], miso_i};
               bit_cnt_q <= bit_cnt_q + ONE;
            end
            if (fall && more_bits) begin
               mosi_q <= tx_q[next_idx];
            end
         end
      end
   end

   assign mosi_o = mosi_q;
   assign rx_o   = rx_q;
endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI transfer sequencer: request handshake, chip select timing, clk_div control, response.
module spi_txn_ctrl
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN   = 16,
   parameter int DIV_W        = 16,
   parameter int CS_SETUP_CYC = 4,
   parameter int CS_HOLD_CYC  = 4,
   localparam int LEN_W       = spi_len_w(SPI_MAXLEN)
) (
   input  logic             clk,
   input  logic             rst,
   spi_txn_ctrl_if.slave    bus,
   output logic             div_start,
   output logic [LEN_W-1:0] div_n_pulses,
   output logic [DIV_W-1:0] div_clk_divide,
   input  logic             div_done,
   input  logic             div_spi_clk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);
   spi_state_e            state_q;
   logic [7:0]            cnt_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [SPI_MAXLEN-1:0] rsp_rx_data_q;
   logic                  div_start_q;
   logic [LEN_W-1:0]      div_n_pulses_q;
   logic [DIV_W-1:0]      div_clk_divide_q;
   logic                  cs_n_q;

   logic                  req_fire;
   logic                  req_len_ok;
   logic                  load;
   logic [DIV_W-1:0]      divide_clamped;
   logic [SPI_MAXLEN-1:0] rx;
   logic [SPI_MAXLEN-1:0] len_mask;

   assign req_fire       = bus.req_valid && req_ready_q;
   assign req_len_ok     = (bus.req_len != '0) && (bus.req_len <= LEN_W'(SPI_MAXLEN));
   assign load           = req_fire && req_len_ok;
   assign divide_clamped = (bus.req_divide < DIV_W'(SPI_MIN_DIVIDE)) ?
                           DIV_W'(SPI_MIN_DIVIDE) : bus.req_divide;
   // div_n_pulses holds the latched length for the whole transfer.
   assign len_mask       = ~({SPI_MAXLEN{1'b1}} << div_n_pulses_q);

   spi_shift_reg #(
      .SPI_MAXLEN (SPI_MAXLEN)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .run_i     (state_q == RUN),
      .len_i     (bus.req_len),
      .tx_i      (bus.req_tx_data),
      .spi_clk_i (div_spi_clk),
      .miso_i    (miso),
      .mosi_o    (mosi),
      .rx_o      (rx)
   );

   // Sequencer FSM with registered outputs. The setup/hold counters act on the
   // cycle they read 1, so the counted phase lasts exactly CS_*_CYC cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         req_ready_q      <= 1'b1;
         rsp_valid_q      <= 1'b0;
         rsp_err_q        <= 1'b0;
         rsp_rx_data_q    <= '0;
         div_start_q      <= 1'b0;
         div_n_pulses_q   <= '0;
         div_clk_divide_q <= DIV_W'(SPI_MIN_DIVIDE);
         cs_n_q           <= 1'b1;
      end else begin
         div_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_fire) begin
                  req_ready_q <= 1'b0;
                  if (req_len_ok) begin
                     div_n_pulses_q   <= bus.req_len;
                     div_clk_divide_q <= divide_clamped;
                     cs_n_q           <= 1'b0;
                     cnt_q            <= 8'(CS_SETUP_CYC);
                     state_q          <= SETUP;
                  end else begin
                     rsp_err_q     <= 1'b1;
                     rsp_rx_data_q <= '0;
                     rsp_valid_q   <= 1'b1;
                     state_q       <= RSP;
                  end
               end
            end
            SETUP: begin
               if (cnt_q == 8'd1) begin
                  div_start_q <= 1'b1;
                  state_q     <= RUN;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RUN: begin
               if (div_done) begin
                  cnt_q   <= 8'(CS_HOLD_CYC);
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (cnt_q == 8'd1) begin
                  cs_n_q        <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  rsp_rx_data_q <= rx & len_mask;
                  rsp_err_q     <= 1'b0;
                  state_q       <= RSP;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_rx_data = rsp_rx_data_q;
   assign div_start       = div_start_q;
   assign div_n_pulses    = div_n_pulses_q;
   assign div_clk_divide  = div_clk_divide_q;
   assign cs_n            = cs_n_q;
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: behavioural clk_div + SPI slave model, directed and random transfers.
module tb_spi_txn_ctrl;
   import spi_pkg::*;

   localparam int M     = 16;
   localparam int DW    = 16;
   localparam int LW    = spi_len_w(M);
   localparam int SETUP = 4;
   localparam int HOLD  = 4;

   logic          clk;
   logic          rst;
   logic          div_start;
   logic [LW-1:0] div_n_pulses;
   logic [DW-1:0] div_clk_divide;
   logic          div_done;
   logic          div_spi_clk;
   logic          cs_n;
   logic          mosi;
   logic          miso;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   spi_txn_ctrl_if #(.SPI_MAXLEN(M), .DIV_W(DW)) bus ();

   spi_txn_ctrl #(
      .SPI_MAXLEN   (M),
      .DIV_W        (DW),
      .CS_SETUP_CYC (SETUP),
      .CS_HOLD_CYC  (HOLD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .div_start      (div_start),
      .div_n_pulses   (div_n_pulses),
      .div_clk_divide (div_clk_divide),
      .div_done       (div_done),
      .div_spi_clk    (div_spi_clk),
      .cs_n           (cs_n),
      .mosi           (mosi),
      .miso           (miso)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ---------------- clk_div + slave model ----------------
   int          miso_mode;      // 0 loopback, 1 tied high, 2 drive miso_word
   logic [M-1:0] miso_word;
   logic [M-1:0] mosi_cap;
   logic [M-1:0] tmp_word;
   int          m_active, m_len, m_half, m_ctr, m_toggles, rises;

   initial begin
      div_done = 1'b0; div_spi_clk = 1'b0; miso = 1'b0;
      m_active = 0; rises = 0; mosi_cap = '0;
      forever begin
         @(posedge clk);
         #2;
         div_done = 1'b0;
         if (rst) begin
            m_active    = 0;
            div_spi_clk = 1'b0;
         end else if (m_active == 0) begin
            if (div_start) begin
               m_active  = 1;
               m_len     = int'(div_n_pulses);
               m_half    = int'(div_clk_divide) / 2;
               if (m_half < 1) m_half = 1;
               m_toggles = 2 * m_len;
               m_ctr     = m_half;
               rises     = 0;
               mosi_cap  = '0;
            end
         end else if (m_ctr > 1) begin
            m_ctr--;
         end else if (m_toggles == 0) begin
            m_active = 0;
            div_done = 1'b1;
         end else begin
            m_ctr = m_half;
            m_toggles--;
            if (!div_spi_clk) begin
               div_spi_clk = 1'b1;
               mosi_cap    = {mosi_cap[M-2:0], mosi};
               if (miso_mode == 0) miso = mosi;
               else if (miso_mode == 1) miso = 1'b1;
               else begin
                  tmp_word = miso_word >> (m_len - 1 - rises);
                  miso     = tmp_word[0];
               end
               rises++;
            end else begin
               div_spi_clk = 1'b0;
            end
         end
      end
   end

   // ---------------- event monitor ----------------
   int   cs_fall_cyc, cs_rise_cyc, cs_fall_n, cs_low_cnt;
   int   start_cnt, start_cyc, np_seen, dv_seen, done_cyc;
   logic cs_prev;

   initial begin
      cs_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (cs_prev && !cs_n) begin cs_fall_cyc = cyc; cs_fall_n++; end
         if (!cs_prev && cs_n) cs_rise_cyc = cyc;
         if (!cs_n) cs_low_cnt++;
         if (div_start) begin
            start_cnt++;
            start_cyc = cyc;
            np_seen   = int'(div_n_pulses);
            dv_seen   = int'(div_clk_divide);
         end
         if (div_done) done_cyc = cyc;
         cs_prev = cs_n;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request and return the cycle in which the handshake happened (-1 on timeout).
   task automatic send_req(input int len, input logic [M-1:0] tx, input int divide, output int hs);
      logic ok;
      @(posedge clk);
      #2;
      cs_fall_cyc = -1; cs_rise_cyc = -1; cs_fall_n = 0; cs_low_cnt = 0;
      start_cnt = 0; start_cyc = -1; np_seen = -1; dv_seen = -1; done_cyc = -1;
      bus.req_valid   = 1'b1;
      bus.req_len     = LW'(len);
      bus.req_tx_data = tx;
      bus.req_divide  = DW'(divide);
      hs = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         ok = bus.req_ready;
         if (ok) hs = cyc;
         @(posedge clk);
         #2;
         if (ok) break;
      end
      bus.req_valid = 1'b0;
      if (hs < 0) chk("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_txn(input int len, input logic [M-1:0] tx, input int divide,
                         input int mode, input logic [M-1:0] mword, input int stall);
      int hs, rc, dv;
      logic valid;
      logic [31:0] mask;
      logic [M-1:0] exp_rx, rx_hold;
      miso_mode = mode;
      miso_word = mword;
      bus.rsp_ready = (stall == 0);
      send_req(len, tx, divide, hs);
      if (hs < 0) return;
      rc = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin rc = cyc; break; end
      end
      if (rc < 0) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         return;
      end
      valid  = (len >= 1) && (len <= M);
      mask   = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
      dv     = (divide < 2) ? 2 : divide;
      exp_rx = !valid ? '0 : (mode == 0) ? (tx & M'(mask)) :
               (mode == 1) ? M'(mask) : (mword & M'(mask));
      chk("rsp_err", 32'(bus.rsp_err), 32'(!valid));
      chk("rsp_rx_data", 32'(bus.rsp_rx_data), 32'(exp_rx));
      if (valid) begin
         chk("cs_fall_cyc", cs_fall_cyc, hs + 1);
         chk("div_start_cyc", start_cyc, hs + 1 + SETUP);
         chk("div_start_count", start_cnt, 1);
         chk("div_n_pulses", np_seen, len);
         chk("div_clk_divide", dv_seen, dv);
         chk("mosi_bits", 32'(mosi_cap & M'(mask)), 32'(tx & M'(mask)));
         chk("rsp_after_done", rc, done_cyc + 1 + HOLD);
         chk("cs_rise_cyc", cs_rise_cyc, rc);
      end else begin
         chk("err_latency", rc, hs + 1);
         chk("no_div_start", start_cnt, 0);
         chk("cs_never_low", cs_low_cnt, 0);
      end
      if (stall > 0) begin
         rx_hold = bus.rsp_rx_data;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #2;
            if (i == 1) begin
               bus.req_valid   = 1'b1;
               bus.req_len     = LW'(8);
               bus.req_tx_data = M'($urandom);
            end
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(bus.rsp_rx_data), 32'(rx_hold));
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
         end
         @(posedge clk);
         #2;
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         chk("stall_cs_fall_count", cs_fall_n, valid ? 1 : 0);
      end
      @(negedge clk);
      chk("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int hs, len, mode;
      bit got3;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_len = '0; bus.req_tx_data = '0; bus.req_divide = '0;
      bus.rsp_ready = 1'b1;
      miso_mode = 0; miso_word = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_rx_data", 32'(bus.rsp_rx_data), 32'd0);
      chk("rst_div_start", 32'(div_start), 32'd0);
      chk("rst_div_n_pulses", 32'(div_n_pulses), 32'd0);
      chk("rst_div_clk_divide", 32'(div_clk_divide), 32'd2);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_mosi", 32'(mosi), 32'd0);
      rst = 1'b0;

      do_txn(8, 16'h00A5, 4, 0, '0, 0);
      do_txn(16, 16'h8001, 4, 1, '0, 0);
      do_txn(0, M'($urandom), 4, 0, '0, 0);
      do_txn(17, M'($urandom), 4, 0, '0, 0);
      do_txn(8, M'($urandom), 0, 2, M'($urandom), 0);
      do_txn(8, M'($urandom), 3, 2, M'($urandom), 20);
      do_txn(1, M'($urandom), 2, 0, '0, 0);
      do_txn(16, M'($urandom), 5, 2, M'($urandom), 0);

      // Reset in the middle of a transfer.
      miso_mode = 0;
      send_req(8, M'($urandom), 8, hs);
      got3 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rises >= 3) begin got3 = 1'b1; break; end
      end
      chk("reached_3_bits", 32'(got3), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(cs_n), 32'd1);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_div_clk_divide", 32'(div_clk_divide), 32'd2);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_txn(4, M'($urandom), 4, 2, M'($urandom), 0);

      for (int t = 0; t < 10; t++) begin
         len  = $urandom_range(0, 17);
         mode = $urandom_range(0, 2);
         do_txn(len, M'($urandom), $urandom_range(0, 6), mode, M'($urandom), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_txn_ctrl.md
# spi_txn_ctrl

Transaction sequencer for the SPI master. It accepts one SPI transfer request (length, transmit word, clock divide) from a host-side valid/ready interface and controls chip select. It configures and starts the `clk_div` pulse generator, shifts MOSI out and samples MISO in on the generated `spi_clk` edges, and returns the received word on a valid/ready response channel. It sits between the register/host interface and `clk_div`, and is the only block that drives `clk_div` control inputs.

## Interface
- `SPI_MAXLEN`, 16: maximum bits per transfer; must match the `clk_div` instance.
- `DIV_W`, 16: width of the clock-divide field.
- `CS_SETUP_CYC`, 4: `clk` cycles from `cs_n` falling to the `div_start` pulse; range 1..255.
- `CS_HOLD_CYC`, 4: `clk` cycles from `div_done` to `cs_n` rising; range 1..255.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req_valid` input, 1 bit; `req_ready` output, 1 bit: request handshake.
- `req_len` input, `$clog2(SPI_MAXLEN)+1` bits: number of bits to transfer.
- `req_tx_data` input, `SPI_MAXLEN` bits: transmit word, right-aligned, sent MSB-first from bit `req_len-1`.
- `req_divide` input, `DIV_W` bits: `spi_clk` divide for this transfer.
- `rsp_valid` output, 1 bit; `rsp_ready` input, 1 bit: response handshake.
- `rsp_rx_data` output, `SPI_MAXLEN` bits: received word, right-aligned, with upper bits zero.
- `rsp_err` output, 1 bit: the request was rejected.
- `div_start` output, 1 bit: one-cycle start pulse to `clk_div`.
- `div_n_pulses` output, `$clog2(SPI_MAXLEN)+1` bits: to `clk_div` `n_pulses`.
- `div_clk_divide` output, `DIV_W` bits: to `clk_div` `CLK_DIVIDE`.
- `div_done` input, 1 bit: from `clk_div`.
- `div_spi_clk` input, 1 bit: from `clk_div` `spi_clk`, synchronous to `clk`.
- `cs_n` output, 1 bit: active-low chip select.
- `mosi` output, 1 bit: serial data out.
- `miso` input, 1 bit: serial data in.

## Operation
- SPI mode 0: `spi_clk` idles low, MISO is sampled on the `spi_clk` rising edge, and MOSI changes on the falling edge.
- Edge detection uses a registered copy of `div_spi_clk`. A rising edge is `!q && d`; a falling edge is `q && !d`.
- States are IDLE, SETUP, RUN, HOLD and RSP.
- IDLE: `req_ready=1`. On a handshake, the block:
  - latches `len`, `tx`, and `divide`, with `divide` clamped to a minimum of 2;
  - clears `rx`;
  - drives `cs_n<=0` and `mosi<=tx[len-1]`;
  - loads the counter with `CS_SETUP_CYC`;
  - moves to SETUP.
- Invalid request (`req_len==0` or `req_len>SPI_MAXLEN`): `cs_n` stays high, `rsp_err<=1`, `rsp_rx_data<=0`, and the block goes directly to RSP.
- SETUP: the counter decrements each cycle. When it reaches 0, the block pulses `div_start` for 1 cycle and moves to RUN.
- RUN:
  - On each rising edge: `rx <= {rx, miso}` and `bit_cnt++`.
  - On each falling edge: if `bit_cnt<len`, MOSI presents the next lower tx bit.
  - On `div_done`: load the counter with `CS_HOLD_CYC` and move to HOLD.
- HOLD: the counter decrements. When it reaches 0: `cs_n<=1`, `rsp_valid<=1`, `rsp_rx_data<=rx` masked to `len` bits, `rsp_err<=0`, move to RSP.
- RSP: `rsp_valid` and its data stay stable until `rsp_ready`. On that handshake the block clears `rsp_valid` and returns to IDLE.
- `div_n_pulses` and `div_clk_divide` are held constant from the request handshake until the block returns to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rx_data=0`;
  - `div_start=0`, `div_n_pulses=0`, `div_clk_divide=2`;
  - `cs_n=1`, `mosi=0`.
- Request handshake at cycle T: `cs_n` is low from T+1, and `div_start` is high in cycle T+1+`CS_SETUP_CYC`.
- `div_done` at cycle D: `cs_n` goes high and `rsp_valid` rises at D+1+`CS_HOLD_CYC`.
- Invalid request at T: `rsp_valid=1, rsp_err=1` at T+1; `cs_n` never toggles.
- `req_ready` is low in every state except IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
- `rsp_ready` already high when `rsp_valid` rises: the response completes in that cycle, and IDLE follows in the next cycle.
- A rising edge coincident with `div_done` is still sampled before HOLD.
- Reset mid-transfer: all outputs return to their reset values asynchronously, so `cs_n` rises immediately. `clk_div` shares `rst` and stops with it.
- Extra `spi_clk` edges beyond `len` are ignored; `bit_cnt` saturates at `len`.

## Structure
- Package `spi_pkg` holds:
  - the `spi_state_e` enum (IDLE, SETUP, RUN, HOLD, RSP);
  - the `SPI_LEN_W` localparam function `$clog2(SPI_MAXLEN)+1`;
  - `SPI_MIN_DIVIDE=2`.
- One natural sub-module: `spi_shift_reg`. It contains the edge detector, the tx/rx shift registers and `bit_cnt`, driven by load/enable signals from the FSM.
- The top level instantiates `spi_shift_reg` only. `clk_div` is instantiated alongside it in `spi_master`, not inside this block.

## Test plan
- `len=8`, tx=0xA5, divide=4, MISO loopback: MOSI carries 1,0,1,0,0,1,0,1; `rsp_rx_data=0x00A5`; `rsp_err=0`; `cs_n` low for exactly setup + 8 `spi_clk` periods + hold.
- `len=16`, tx=0x8001, MISO tied to 1: `rsp_rx_data=0xFFFF`; `div_n_pulses=16`; `div_start` at T+1+4.
- `len=0` and `len=17`: `rsp_err=1` one cycle after the handshake; `cs_n` stays 1; `div_start` never pulses.
- `req_divide=0`: `div_clk_divide=2` and the transfer completes normally.
- `rsp_ready` held low for 20 cycles: `rsp_valid` and data stay stable, `req_ready` stays 0, and a new `req_valid` is not accepted.
- Assert `rst` mid-RUN after 3 bits: `cs_n=1` and `rsp_valid=0` immediately; after reset is released, a fresh `len=4` transfer completes correctly.
